// File: rtl/mod_n_cnt_univ.sv
// -----------------------------------------------------------------------------
// mod_n_cnt_univ
//   Programmable modulus counter (modulus = limit + 1) with up/down counting,
//   count enable, synchronous clear, parallel load and an optional one-shot
//   mode that stops at the terminal value and raises done.
//
// Ports
//   clk     in   1      rising-edge clock
//   reset   in   1      synchronous, active-low reset
//   en      in   1      count enable (hold when 0)
//   clr     in   1      synchronous clear: q <= 0, done <= 0
//   load    in   1      synchronous load:  q <= d, done <= 0
//   d       in   WIDTH  load value
//   up      in   1      1 = count up, 0 = count down
//   limit   in   WIDTH  terminal value
//   q       out  WIDTH  registered count
//   at_max  out  1      q == limit
//   at_min  out  1      q == 0
//   tc      out  1      terminal-count pulse for the edge that wraps or stops
//   done    out  1      one-shot finished flag (0 when ONE_SHOT = 0)
// -----------------------------------------------------------------------------
module mod_n_cnt_univ #(
  parameter int WIDTH    = 8,
  parameter bit ONE_SHOT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             up,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             done_q, done_d;
  logic             term;
  logic             step;

  // In up mode ">=" rather than "==" so a count left above a freshly lowered
  // limit (or loaded above it) still wraps cleanly on the next step.
  always_comb begin
    term = up ? (q_q >= limit) : (q_q == '0);
    step = en & ~done_q;
    tc   = reset & en & ~clr & ~load & ~done_q & term;
  end

  always_comb begin
    q_d    = q_q;
    done_d = done_q;
    if (clr) begin
      q_d    = '0;
      done_d = 1'b0;
    end else if (load) begin
      q_d    = d;
      done_d = 1'b0;
    end else if (step) begin
      if (ONE_SHOT && term) begin
        // One-shot: freeze on the terminal value instead of wrapping.
        done_d = 1'b1;
      end else if (up) begin
        q_d = (q_q >= limit) ? '0 : q_q + WIDTH'(1);
      end else begin
        // Out-of-range counts re-enter at limit rather than walking down.
        q_d = ((q_q == '0) || (q_q > limit)) ? limit : q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_q    <= '0;
      done_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      done_q <= done_d;
    end
  end

  assign q      = q_q;
  assign at_max = (q_q == limit);
  assign at_min = (q_q == '0);
  assign done   = ONE_SHOT ? done_q : 1'b0;

endmodule

// File: tb/tb_mod_n_cnt_univ.sv
// -----------------------------------------------------------------------------
// tb_mod_n_cnt_univ
//   Exercises three counter instances that share their control inputs:
//     dut_a : WIDTH=8, free running
//     dut_o : WIDTH=8, one-shot
//     dut_4 : WIDTH=4, free running
// -----------------------------------------------------------------------------
module tb_mod_n_cnt_univ;

  logic       clk = 1'b0;
  logic       reset, en, clr, load, up;
  logic [7:0] d8, limit8;
  logic [3:0] d4, limit4;

  logic [7:0] q_a, q_o;
  logic [3:0] q_4;
  logic       at_max_a, at_min_a, tc_a, done_a;
  logic       at_max_o, at_min_o, tc_o, done_o;
  logic       at_max_4, at_min_4, tc_4, done_4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_n_cnt_univ #(.WIDTH(8), .ONE_SHOT(1'b0)) dut_a (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .d(d8), .up(up),
    .limit(limit8), .q(q_a), .at_max(at_max_a), .at_min(at_min_a), .tc(tc_a), .done(done_a)
  );

  mod_n_cnt_univ #(.WIDTH(8), .ONE_SHOT(1'b1)) dut_o (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .d(d8), .up(up),
    .limit(limit8), .q(q_o), .at_max(at_max_o), .at_min(at_min_o), .tc(tc_o), .done(done_o)
  );

  mod_n_cnt_univ #(.WIDTH(4), .ONE_SHOT(1'b0)) dut_4 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .load(load), .d(d4), .up(up),
    .limit(limit4), .q(q_4), .at_max(at_max_4), .at_min(at_min_4), .tc(tc_4), .done(done_4)
  );

  // Directed vectors for the free-running 8-bit instance. exp_q / exp_tc are
  // the values seen with these inputs applied, before the next clock edge.
  typedef struct {
    logic       rst_n, en, clr, load, up;
    logic [7:0] d, limit, exp_q;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(logic r, logic e, logic c, logic l, logic u,
                                 logic [7:0] dv, logic [7:0] lv,
                                 logic [7:0] eq, logic et);
    vec_t v;
    v.rst_n = r; v.en = e; v.clr = c; v.load = l; v.up = u;
    v.d = dv; v.limit = lv; v.exp_q = eq; v.exp_tc = et;
    vecs.push_back(v);
  endfunction

  // Drive every shared input from one place
  task automatic applyStimulus(input logic r, input logic e, input logic c,
                               input logic l, input logic u,
                               input logic [7:0] dv, input logic [7:0] lv,
                               input logic [3:0] d4v, input logic [3:0] l4v);
    reset = r; en = e; clr = c; load = l; up = u;
    d8 = dv; limit8 = lv; d4 = d4v; limit4 = l4v;
  endtask

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: one counter described by its arithmetic rules
  typedef struct {
    int q;
    bit done;
  } model_t;

  function automatic bit modelTerm(model_t m, int lim, bit u);
    return u ? (m.q >= lim) : (m.q == 0);
  endfunction

  function automatic bit modelTc(model_t m, int lim, bit u, bit r, bit e, bit c, bit l);
    return r && e && !c && !l && !m.done && modelTerm(m, lim, u);
  endfunction

  function automatic model_t modelNext(model_t m, bit os, int lim, int dv,
                                       bit r, bit e, bit c, bit l, bit u);
    model_t n = m;
    if (!r || c) begin
      n.q = 0; n.done = 1'b0;
    end else if (l) begin
      n.q = dv; n.done = 1'b0;
    end else if (e && !m.done) begin
      if (os && modelTerm(m, lim, u)) n.done = 1'b1;
      else if (u) n.q = (m.q < lim) ? m.q + 1 : 0;
      else n.q = (m.q >= 1 && m.q <= lim) ? m.q - 1 : lim;
    end
    return n;
  endfunction

  initial begin
    model_t ma, mo, m4;
    bit     etA, etO, et4;
    bit     rr, re, rc, rl, ru;
    logic [7:0] rd, rlim;
    logic [3:0] rd4, rlim4;

    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd0, 4'd0, 4'd0);
    cycle();
    cycle();

    // Reset state: limit 0 makes at_max true as well
    checkOutput("reset_q", 32'(q_a), 32'd0);
    checkOutput("reset_tc", 32'(tc_a), 32'd0);
    checkOutput("reset_at_min", 32'(at_min_a), 32'd1);
    checkOutput("reset_at_max", 32'(at_max_a), 32'd1);
    checkOutput("reset_done_o", 32'(done_o), 32'd0);

    // Up count, limit 9: 0..9 then wrap
    for (int i = 0; i < 10; i++) addVec(1, 1, 0, 0, 1, 8'd0, 8'd9, 8'(i), i == 9);
    addVec(1, 1, 0, 0, 1, 8'd0, 8'd9, 8'd0, 0);
    // Clear, then down count with limit 4
    addVec(1, 1, 1, 0, 0, 8'd0, 8'd4, 8'd1, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd0, 1);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd4, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd3, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd2, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd1, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd0, 1);
    addVec(1, 0, 0, 0, 0, 8'd0, 8'd4, 8'd4, 0);
    addVec(1, 0, 0, 0, 0, 8'd0, 8'd4, 8'd4, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd4, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd3, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd2, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd1, 0);
    // Enable low on the terminal value: hold and no tc
    addVec(1, 0, 0, 0, 0, 8'd0, 8'd4, 8'd0, 0);
    addVec(1, 0, 0, 0, 0, 8'd0, 8'd4, 8'd0, 0);
    addVec(1, 1, 0, 0, 0, 8'd0, 8'd4, 8'd0, 1);
    // Load above limit, then wrap
    addVec(1, 1, 0, 1, 1, 8'd200, 8'd5, 8'd4, 0);
    addVec(1, 1, 0, 0, 1, 8'd0, 8'd5, 8'd200, 1);
    addVec(1, 1, 0, 0, 1, 8'd0, 8'd5, 8'd0, 0);
    // Limit lowered below current count
    addVec(1, 1, 0, 1, 1, 8'd7, 8'd9, 8'd1, 0);
    addVec(1, 1, 0, 0, 1, 8'd0, 8'd3, 8'd7, 1);
    addVec(1, 1, 0, 0, 1, 8'd0, 8'd3, 8'd0, 0);
    // Clear beats load
    addVec(1, 1, 1, 1, 1, 8'd50, 8'd3, 8'd1, 0);
    addVec(1, 0, 0, 1, 1, 8'd5, 8'd3, 8'd0, 0);
    // Reset beats load and enable, tc forced low
    addVec(0, 1, 0, 1, 1, 8'd77, 8'd3, 8'd5, 0);
    addVec(1, 0, 0, 0, 1, 8'd0, 8'd3, 8'd0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].en, vecs[i].clr, vecs[i].load, vecs[i].up,
                    vecs[i].d, vecs[i].limit, 4'd0, 4'd0);
      #1;
      checkOutput($sformatf("vec%0d_q", i), 32'(q_a), 32'(vecs[i].exp_q));
      checkOutput($sformatf("vec%0d_tc", i), 32'(tc_a), 32'(vecs[i].exp_tc));
      checkOutput($sformatf("vec%0d_at_max", i), 32'(at_max_a),
                  32'(vecs[i].exp_q == vecs[i].limit));
      checkOutput($sformatf("vec%0d_at_min", i), 32'(at_min_a), 32'(vecs[i].exp_q == 8'd0));
      cycle();
    end

    // One-shot instance, limit 3: single tc, then frozen with done
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd3, 4'd0, 4'd15);
    cycle();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 8'd0, 8'd3, 4'd0, 4'd15);
      #1;
      checkOutput($sformatf("os_q%0d", i), 32'(q_o), 32'(i));
      checkOutput($sformatf("os_tc%0d", i), 32'(tc_o), 32'(i == 3));
      checkOutput($sformatf("os_done%0d", i), 32'(done_o), 32'd0);
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("os_hold_q%0d", i), 32'(q_o), 32'd3);
      checkOutput($sformatf("os_hold_done%0d", i), 32'(done_o), 32'd1);
      checkOutput($sformatf("os_hold_tc%0d", i), 32'(tc_o), 32'd0);
      cycle();
    end
    applyStimulus(1, 1, 0, 1, 1, 8'd1, 8'd3, 4'd0, 4'd15);
    cycle();
    applyStimulus(1, 1, 0, 0, 1, 8'd0, 8'd3, 4'd0, 4'd15);
    #1;
    checkOutput("os_reload_q", 32'(q_o), 32'd1);
    checkOutput("os_reload_done", 32'(done_o), 32'd0);
    cycle();
    checkOutput("os_restart_q", 32'(q_o), 32'd2);
    cycle();
    checkOutput("os_restart_tc", 32'(tc_o), 32'd1);

    // 4-bit full range: 0..15 wrap, then limit 0 divide-by-1
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd3, 4'd0, 4'd15);
    cycle();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 8'd0, 8'd3, 4'd0, 4'd15);
      #1;
      checkOutput($sformatf("w4_q%0d", i), 32'(q_4), 32'(i));
      checkOutput($sformatf("w4_tc%0d", i), 32'(tc_4), 32'(i == 15));
      cycle();
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 1, 0, 0, 1, 8'd0, 8'd3, 4'd0, 4'd0);
      #1;
      checkOutput($sformatf("div1_q%0d", i), 32'(q_4), 32'd0);
      checkOutput($sformatf("div1_tc%0d", i), 32'(tc_4), 32'd1);
      checkOutput($sformatf("div1_at_max%0d", i), 32'(at_max_4), 32'd1);
      cycle();
    end

    // Randomised run against the reference model
    applyStimulus(0, 0, 0, 0, 1, 8'd0, 8'd10, 4'd0, 4'd9);
    cycle();
    ma = '{0, 1'b0}; mo = '{0, 1'b0}; m4 = '{0, 1'b0};
    rlim = 8'd10; rlim4 = 4'd9; ru = 1'b1;
    for (int i = 0; i < 600; i++) begin
      rr = ($urandom_range(0, 99) >= 2);
      re = ($urandom_range(0, 99) < 80);
      rc = ($urandom_range(0, 99) < 3);
      rl = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 10) ru = ~ru;
      if ($urandom_range(0, 99) < 5) begin
        rlim  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
        rlim4 = 4'($urandom);
      end
      rd  = 8'($urandom);
      rd4 = 4'($urandom);
      applyStimulus(rr, re, rc, rl, ru, rd, rlim, rd4, rlim4);
      #1;
      etA = modelTc(ma, int'(rlim), ru, rr, re, rc, rl);
      etO = modelTc(mo, int'(rlim), ru, rr, re, rc, rl);
      et4 = modelTc(m4, int'(rlim4), ru, rr, re, rc, rl);
      checkOutput("rnd_a_q", 32'(q_a), 32'(ma.q));
      checkOutput("rnd_a_tc", 32'(tc_a), 32'(etA));
      checkOutput("rnd_a_at_max", 32'(at_max_a), 32'(ma.q == int'(rlim)));
      checkOutput("rnd_a_done", 32'(done_a), 32'd0);
      checkOutput("rnd_o_q", 32'(q_o), 32'(mo.q));
      checkOutput("rnd_o_tc", 32'(tc_o), 32'(etO));
      checkOutput("rnd_o_done", 32'(done_o), 32'(mo.done));
      checkOutput("rnd_o_at_min", 32'(at_min_o), 32'(mo.q == 0));
      checkOutput("rnd_4_q", 32'(q_4), 32'(m4.q));
      checkOutput("rnd_4_tc", 32'(tc_4), 32'(et4));
      checkOutput("rnd_4_done", 32'(done_4), 32'd0);
      ma = modelNext(ma, 1'b0, int'(rlim), int'(rd), rr, re, rc, rl, ru);
      mo = modelNext(mo, 1'b1, int'(rlim), int'(rd), rr, re, rc, rl, ru);
      m4 = modelNext(m4, 1'b0, int'(rlim4), int'(rd4), rr, re, rc, rl, ru);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
